// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with thresholds, occupancy count and optional FWFT read
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 32,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           din,
  input  logic                       wr_en,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_AF    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] C_AE    = (AW+1)'(AE_LEVEL);
  localparam logic [AW:0] C_ONE   = (AW+1)'(1);

  // Storage is deliberately not reset; pointers alone define valid contents.
  logic [WIDTH-1:0] r_mem [DEPTH];

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [AW:0] r_count;
  logic        r_overflow;
  logic        r_underflow;

  logic            w_full;
  logic            w_empty;
  logic            w_wr_acc;
  logic            w_rd_acc;
  logic [AW:0]     w_wr_ptr_nxt;
  logic [AW:0]     w_rd_ptr_nxt;
  logic [WIDTH-1:0] w_mem_rd;

  // Status decodes only from the registered count.
  assign w_full       = (r_count == C_DEPTH);
  assign w_empty      = (r_count == '0);
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= C_AF);
  assign almost_empty = (r_count <= C_AE);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // A blocked request is never rescued by the opposite request in the same cycle.
  assign w_wr_acc     = wr_en && !w_full;
  assign w_rd_acc     = rd_en && !w_empty;
  assign w_wr_ptr_nxt = w_wr_acc ? (r_wr_ptr + C_ONE) : r_wr_ptr;
  assign w_rd_ptr_nxt = w_rd_acc ? (r_rd_ptr + C_ONE) : r_rd_ptr;
  assign w_mem_rd     = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer, occupancy and sticky error flag update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_wr_ptr_nxt - w_rd_ptr_nxt;
      if (wr_en && w_full) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Memory write; requests during reset are ignored.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_acc) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is shown directly; meaningless while empty.
      assign dout = w_mem_rd;
    end else begin : g_std
      logic [WIDTH-1:0] r_dout;

      // Output register loads the head entry on an accepted read, else holds.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_dout <= '0;
        end else if (w_rd_acc) begin
          r_dout <= w_mem_rd;
        end
      end

      assign dout = r_dout;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - self-checking bench for sync_fifo_param (std, FWFT and default-parameter instances)
module tb_sync_fifo_param;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       wr_en;
  logic       rd_en;

  logic [7:0] dout_a, dout_b, dout_c;
  logic       full_a, full_b, full_c;
  logic       empty_a, empty_b, empty_c;
  logic       af_a, af_b, af_c;
  logic       ae_a, ae_b, ae_c;
  logic [3:0] count_a, count_b;
  logic [5:0] count_c;
  logic       ov_a, ov_b, ov_c;
  logic       un_a, un_b, un_c;

  int n_checks;
  int n_errors;
  bit chk_en;

  // Reference model: plain queues plus sticky flags and a registered-read copy.
  logic [7:0] q8[$];
  logic [7:0] q32[$];
  bit         ov8, un8, ov32, un32;
  logic [7:0] md8, md32;

  sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(0)) u_a (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout_a), .full(full_a), .empty(empty_a), .almost_full(af_a),
    .almost_empty(ae_a), .count(count_a), .overflow(ov_a), .underflow(un_a)
  );

  sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1)) u_b (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout_b), .full(full_b), .empty(empty_b), .almost_full(af_b),
    .almost_empty(ae_b), .count(count_b), .overflow(ov_b), .underflow(un_b)
  );

  sync_fifo_param u_c (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout_c), .full(full_c), .empty(empty_c), .almost_full(af_c),
    .almost_empty(ae_c), .count(count_c), .overflow(ov_c), .underflow(un_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit w, input bit rd, input logic [7:0] d);
    bit wa, ra;
    rst = r; wr_en = w; rd_en = rd; din = d;
    @(posedge clk);
    if (r) begin
      q8.delete(); q32.delete();
      ov8 = 0; un8 = 0; ov32 = 0; un32 = 0;
      md8 = 8'h00; md32 = 8'h00;
    end else begin
      if (w && q8.size() == 8) ov8 = 1;
      if (rd && q8.size() == 0) un8 = 1;
      wa = w && (q8.size() < 8);
      ra = rd && (q8.size() > 0);
      if (ra) md8 = q8.pop_front();
      if (wa) q8.push_back(d);
      if (w && q32.size() == 32) ov32 = 1;
      if (rd && q32.size() == 0) un32 = 1;
      wa = w && (q32.size() < 32);
      ra = rd && (q32.size() > 0);
      if (ra) md32 = q32.pop_front();
      if (wa) q32.push_back(d);
    end
    chk_en = 1;
    @(negedge clk);
  endtask

  // Every cycle: all three instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_count", int'(count_a), q8.size());
      chk("a_empty", int'(empty_a), int'(q8.size() == 0));
      chk("a_full",  int'(full_a),  int'(q8.size() == 8));
      chk("a_af",    int'(af_a),    int'(q8.size() >= 6));
      chk("a_ae",    int'(ae_a),    int'(q8.size() <= 1));
      chk("a_ovf",   int'(ov_a),    int'(ov8));
      chk("a_unf",   int'(un_a),    int'(un8));
      chk("a_dout",  int'(dout_a),  int'(md8));
      chk("b_count", int'(count_b), q8.size());
      chk("b_empty", int'(empty_b), int'(q8.size() == 0));
      chk("b_full",  int'(full_b),  int'(q8.size() == 8));
      chk("b_af",    int'(af_b),    int'(q8.size() >= 6));
      chk("b_ae",    int'(ae_b),    int'(q8.size() <= 1));
      chk("b_ovf",   int'(ov_b),    int'(ov8));
      chk("b_unf",   int'(un_b),    int'(un8));
      if (q8.size() > 0) chk("b_dout", int'(dout_b), int'(q8[0]));
      chk("c_count", int'(count_c), q32.size());
      chk("c_empty", int'(empty_c), int'(q32.size() == 0));
      chk("c_full",  int'(full_c),  int'(q32.size() == 32));
      chk("c_af",    int'(af_c),    int'(q32.size() >= 30));
      chk("c_ae",    int'(ae_c),    int'(q32.size() <= 2));
      chk("c_ovf",   int'(ov_c),    int'(ov32));
      chk("c_unf",   int'(un_c),    int'(un32));
      chk("c_dout",  int'(dout_c),  int'(md32));
    end
  end

  initial begin
    n_checks = 0; n_errors = 0; chk_en = 0;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
    @(negedge clk);

    // Reset then idle.
    step(1, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    chk("lit_reset_count", int'(count_a), 0);
    chk("lit_reset_dout", int'(dout_a), 0);
    chk("lit_reset_empty", int'(empty_a), 1);
    chk("lit_reset_ae", int'(ae_a), 1);

    // Fill 0x01..0x08, then drain.
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 0, 8'(i));
      if (i == 1) chk("lit_ae_at1", int'(ae_a), 1);
      if (i == 2) chk("lit_ae_at2", int'(ae_a), 0);
      if (i == 5) chk("lit_af_at5", int'(af_a), 0);
      if (i == 6) chk("lit_af_at6", int'(af_a), 1);
    end
    chk("lit_fill_count", int'(count_a), 8);
    chk("lit_fill_full", int'(full_a), 1);
    chk("lit_fwft_head", int'(dout_b), 8'h01);
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 1, 8'h00);
      chk("lit_drain_dout", int'(dout_a), i);
    end
    chk("lit_drain_empty", int'(empty_a), 1);

    // Overflow on full, then underflow on empty.
    for (int i = 1; i <= 8; i++) step(0, 1, 0, 8'(i));
    step(0, 1, 0, 8'hAA);
    chk("lit_ovf", int'(ov_a), 1);
    chk("lit_ovf_count", int'(count_a), 8);
    step(0, 1, 1, 8'hAB);
    chk("lit_full_rw_count", int'(count_a), 7);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 8'h00);
    chk("lit_last_dout", int'(dout_a), 8'h08);
    step(0, 0, 1, 8'h00);
    chk("lit_unf", int'(un_a), 1);
    chk("lit_unf_dout", int'(dout_a), 8'h08);
    step(0, 1, 1, 8'h33);
    chk("lit_empty_rw_count", int'(count_a), 1);
    step(0, 0, 1, 8'h00);

    // Preload 4 then 20 cycles of simultaneous read/write across pointer wrap.
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'(8'h10 + i));
    for (int i = 0; i < 20; i++) step(0, 1, 1, 8'(8'h14 + i));
    chk("lit_stream_count", int'(count_a), 4);
    chk("lit_stream_dout", int'(dout_a), 8'h23);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00);
    chk("lit_stream_tail", int'(dout_a), 8'h27);

    // FWFT visibility of a single write into empty.
    step(1, 0, 0, 8'h00);
    step(0, 1, 0, 8'h5C);
    chk("lit_fwft_5c", int'(dout_b), 8'h5C);
    chk("lit_fwft_nonempty", int'(empty_b), 0);

    // Reset at count 5 with wr_en high; writes restart from address 0.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'(8'h60 + i));
    chk("lit_pre_rst_count", int'(count_a), 5);
    step(1, 1, 0, 8'hEE);
    chk("lit_rst_count", int'(count_a), 0);
    chk("lit_rst_empty", int'(empty_a), 1);
    chk("lit_rst_ovf", int'(ov_a), 0);
    chk("lit_rst_unf", int'(un_a), 0);
    step(0, 1, 0, 8'h77);
    chk("lit_restart_fwft", int'(dout_b), 8'h77);
    step(0, 0, 1, 8'h00);
    chk("lit_restart_dout", int'(dout_a), 8'h77);
    step(0, 0, 0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
